// File: rtl/cache_ctrl_core_if.sv
// Request/response bundle between the SRAM adapter, the word cache
// and the backing memory port.
interface cache_ctrl_core_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_rd_en;
  logic                  i_wr_en;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [31:0]           i_data;
  logic [3:0]            i_mask;
  logic [31:0]           o_data;
  logic                  o_busy;
  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    output i_rd_en, i_wr_en, i_addr, i_data, i_mask,
    input  o_data, o_busy,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  i_rd_en, i_wr_en, i_addr, i_data, i_mask,
    output o_data, o_busy,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_ctrl_core.sv
// Direct-mapped write-through, no-write-allocate word cache in front
// of a word-wide backing memory.
module cache_ctrl_core #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8
) (
  input logic              clk,
  input logic              rst_x,
  cache_ctrl_core_if.slave bus
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL, WRITE, DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wmask_q;
  logic [31:0]           data_q;
  logic                  lk_valid;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [31:0]           lk_data;
  logic [LINES-1:0]      valid;

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] idx_in;
  logic [INDEX_BITS-1:0] idx_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic                  lookup;
  logic                  hit;
  logic                  busy;
  logic                  accept;
  logic                  fill_ack;
  logic                  wr_ack;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  assign idx_in   = bus.i_addr[INDEX_BITS+1:2];
  assign idx_q    = addr_q[INDEX_BITS+1:2];
  assign tag_q    = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign lookup   = (state == LOOKUP);
  assign hit      = lk_valid && (lk_tag == tag_q);
  // A lookup miss raises the fill request in the lookup cycle itself.
  assign busy     = (state == FILL) || (state == WRITE)
                 || (lookup && !hit);
  assign accept   = !busy && (bus.i_rd_en || bus.i_wr_en);
  assign fill_ack = bus.mem_ack
                 && ((state == FILL) || (lookup && !hit));
  assign wr_ack   = bus.mem_ack && (state == WRITE);

  assign bus.o_busy     = busy;
  assign bus.o_data     = (lookup && hit) ? lk_data : data_q;
  assign bus.mem_rd_req = (state == FILL) || (lookup && !hit);
  assign bus.mem_wr_req = (state == WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wmask  = wmask_q;

  always_ff @(posedge clk) begin
    if (rst_x) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      data_q   <= '0;
      lk_valid <= 1'b0;
      lk_tag   <= '0;
      lk_data  <= '0;
      valid    <= '0;
    end else begin
      if (accept) begin
        state    <= bus.i_wr_en ? WRITE : LOOKUP;
        addr_q   <= bus.i_addr & ~ADDR_WIDTH'(3);
        wdata_q  <= bus.i_data;
        wmask_q  <= bus.i_mask;
        lk_valid <= valid[idx_in];
        lk_tag   <= tag_mem[idx_in];
        lk_data  <= data_mem[idx_in];
      end else begin
        case (state)
          IDLE:    state <= IDLE;
          LOOKUP:  state <= hit ? IDLE
                          : (bus.mem_ack ? DONE : FILL);
          FILL:    if (bus.mem_ack) state <= DONE;
          WRITE:   if (bus.mem_ack) state <= DONE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      if (lookup && hit) data_q <= lk_data;
      if (fill_ack) begin
        data_q       <= bus.mem_rdata;
        valid[idx_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_x && fill_ack) begin
      tag_mem[idx_q]  <= tag_q;
      data_mem[idx_q] <= bus.mem_rdata;
    end
    if (!rst_x && wr_ack && hit) begin
      data_mem[idx_q] <= merge(data_mem[idx_q], wdata_q, wmask_q);
    end
  end

endmodule

// File: tb/tb_cache_ctrl_core.sv
// Bench for cache_ctrl_core: vector table, backing memory model with
// fixed ack latency, and a read-data scoreboard.
module tb_cache_ctrl_core;

  localparam int LAT = 3;

  logic clk;
  logic rst_x;

  cache_ctrl_core_if #(.ADDR_WIDTH(32)) bus ();

  cache_ctrl_core #(
    .ADDR_WIDTH(32),
    .INDEX_BITS(8)
  ) dut (
    .clk  (clk),
    .rst_x(rst_x),
    .bus  (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    bit          mem;
    logic [31:0] exp;
    string       name;
  } vec_t;

  int checks;
  int passed;
  int rd_txn;
  int wr_txn;
  int req_cnt;
  int last_cycles;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wmask;
  bit [31:0]   mem_model [1024];
  bit          mem_set   [1024];
  bit          auto_ack;
  bit          force_ack;
  logic [31:0] exp_q [$];
  vec_t        tbl [$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (32'h5A000000 ^ a);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    return mem_set[w[11:2]] ? mem_model[w[11:2]] : dflt(w);
  endfunction

  function automatic logic [31:0] bmerge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Backing memory: acks in the LAT-th cycle a request is seen.
  always @(negedge clk) begin
    if (force_ack) begin
      bus.mem_ack   <= 1'b1;
      bus.mem_rdata <= 32'h12345678;
    end else if (auto_ack && (bus.mem_rd_req || bus.mem_wr_req)
                 && !bus.mem_ack) begin
      if (req_cnt + 1 == LAT) begin
        bus.mem_ack <= 1'b1;
        req_cnt     <= 0;
        last_cycles <= req_cnt + 1;
        last_addr   <= bus.mem_addr;
        last_wdata  <= bus.mem_wdata;
        last_wmask  <= bus.mem_wmask;
        if (bus.mem_wr_req) begin
          mem_model[bus.mem_addr[11:2]] <=
            bmerge(model_read(bus.mem_addr), bus.mem_wdata,
                   bus.mem_wmask);
          mem_set[bus.mem_addr[11:2]] <= 1'b1;
          wr_txn <= wr_txn + 1;
        end else begin
          bus.mem_rdata <= model_read(bus.mem_addr);
          rd_txn <= rd_txn + 1;
        end
      end else begin
        bus.mem_ack <= 1'b0;
        req_cnt     <= req_cnt + 1;
      end
    end else begin
      bus.mem_ack <= 1'b0;
      if (!(bus.mem_rd_req || bus.mem_wr_req)) req_cnt <= 0;
    end
  end

  task automatic xact(input vec_t v);
    int          rd0;
    int          wr0;
    int          cyc;
    bit          busy_seen;
    bit          is_rd;
    logic [31:0] od0;
    logic [31:0] expd;
    is_rd = v.rd && !v.wr;
    rd0   = rd_txn;
    wr0   = wr_txn;
    od0   = bus.o_data;
    bus.i_rd_en = v.rd;
    bus.i_wr_en = v.wr;
    bus.i_addr  = v.addr;
    bus.i_data  = v.data;
    bus.i_mask  = v.mask;
    if (is_rd) exp_q.push_back(model_read(v.addr));
    @(posedge clk); #1;
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    busy_seen = bus.o_busy;
    if (v.mem)
      check({v.name, "_req"},
            v.wr ? bus.mem_wr_req : bus.mem_rd_req, 1);
    else
      check({v.name, "_zero_wait"}, busy_seen, 0);
    cyc = 0;
    while (bus.o_busy && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({v.name, "_done"}, bus.o_busy, 0);
    check({v.name, "_rd_txn"}, rd_txn - rd0, (is_rd && v.mem));
    check({v.name, "_wr_txn"}, wr_txn - wr0, v.wr);
    if (v.mem) begin
      check({v.name, "_addr"}, last_addr, v.addr & ~32'd3);
      check({v.name, "_req_cycles"}, last_cycles, LAT);
    end
    if (v.wr) begin
      check({v.name, "_busy_seen"}, busy_seen, 1);
      check({v.name, "_wdata"}, last_wdata, v.data);
      check({v.name, "_wmask"}, {28'd0, last_wmask}, {28'd0, v.mask});
      check({v.name, "_odata_kept"}, bus.o_data, od0);
    end
    if (is_rd) begin
      expd = exp_q.pop_front();
      check({v.name, "_sb"}, bus.o_data, expd);
      check({v.name, "_data"}, bus.o_data, v.exp);
    end
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    auto_ack  = 1'b1;
    force_ack = 1'b0;
    rst_x       = 1'b1;
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_addr  = '0;
    bus.i_data  = '0;
    bus.i_mask  = '0;

    tbl.push_back('{1, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF, "cold_rd"});
    tbl.push_back('{1, 0, 32'h102, 0, 0, 0, 32'hDEADBEEF, "hit_rd"});
    tbl.push_back('{1, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF, "b2b_rd"});
    tbl.push_back('{0, 1, 32'h100, 32'h11223344, 4'b0011, 1, 0,
                    "wr_hit"});
    tbl.push_back('{1, 0, 32'h100, 0, 0, 0, 32'hDEAD3344, "rd_merged"});
    tbl.push_back('{0, 1, 32'h200, 32'h55667788, 4'b1111, 1, 0,
                    "wr_miss"});
    tbl.push_back('{1, 0, 32'h200, 0, 0, 1, 32'h55667788, "no_alloc"});
    tbl.push_back('{1, 0, 32'h500, 0, 0, 1, 32'h5A000500, "alias"});
    tbl.push_back('{1, 0, 32'h100, 0, 0, 1, 32'hDEAD3344, "evicted"});
    tbl.push_back('{1, 1, 32'h104, 32'hCAFEF00D, 4'b1111, 1, 0,
                    "rd_wr_both"});
    tbl.push_back('{1, 0, 32'h104, 0, 0, 1, 32'hCAFEF00D, "rd_104"});
    tbl.push_back('{0, 1, 32'h104, 32'hFFFFFFFF, 4'b0000, 1, 0,
                    "wr_mask0"});
    tbl.push_back('{1, 0, 32'h104, 0, 0, 0, 32'hCAFEF00D, "rd_mask0"});
    tbl.push_back('{0, 1, 32'h104, 32'hAB000000, 4'b1000, 1, 0,
                    "wr_top"});
    tbl.push_back('{1, 0, 32'h104, 0, 0, 0, 32'hABFEF00D, "rd_top"});
    tbl.push_back('{1, 0, 32'h3FC, 0, 0, 1, 32'h5A0003FC, "last_idx"});
    tbl.push_back('{1, 0, 32'h3FC, 0, 0, 0, 32'h5A0003FC, "last_hit"});
    tbl.push_back('{1, 0, 32'h500, 0, 0, 1, 32'h5A000500, "alias2"});
    tbl.push_back('{1, 0, 32'h100, 0, 0, 1, 32'hDEAD3344, "refill"});
    tbl.push_back('{1, 0, 32'h100, 0, 0, 0, 32'hDEAD3344, "pre_rst"});

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.o_busy, 0);
    check("rst_rd_req", bus.mem_rd_req, 0);
    check("rst_wr_req", bus.mem_wr_req, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_wmask", {28'd0, bus.mem_wmask}, 0);
    check("rst_odata", bus.o_data, 0);
    rst_x = 1'b0;

    foreach (tbl[i]) xact(tbl[i]);

    // Reset in the middle of a fill, then a stray ack.
    auto_ack    = 1'b0;
    bus.i_rd_en = 1'b1;
    bus.i_addr  = 32'h904;
    @(posedge clk); #1;
    bus.i_rd_en = 1'b0;
    check("fill_req_up", bus.mem_rd_req, 1);
    @(posedge clk); #1;
    check("fill_busy", bus.o_busy, 1);
    rst_x = 1'b1;
    @(posedge clk); #1;
    rst_x = 1'b0;
    check("abort_busy", bus.o_busy, 0);
    check("abort_rd_req", bus.mem_rd_req, 0);
    check("abort_addr", bus.mem_addr, 0);
    check("abort_odata", bus.o_data, 0);
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    check("late_ack_busy", bus.o_busy, 0);
    check("late_ack_rd_req", bus.mem_rd_req, 0);
    check("late_ack_odata", bus.o_data, 0);
    auto_ack = 1'b1;
    @(negedge clk);

    xact('{1, 0, 32'h100, 0, 0, 1, 32'hDEAD3344, "post_rst_100"});
    xact('{1, 0, 32'h904, 0, 0, 1, 32'h5A000904, "post_rst_904"});
    xact('{1, 0, 32'h904, 0, 0, 0, 32'h5A000904, "post_rst_hit"});

    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
